// File: rtl/remote_send.sv
// remote_send -- NEC infrared transmitter.
//
// On send_req this block transmits one full NEC data frame. The frame is a lead
// burst, a lead space, the 32 bits {~cmd, cmd, ~addr, addr} sent LSB first, a stop
// burst and a trailing gap. On repeat_req it transmits the NEC repeat code instead:
// a lead burst, a short lead space, a stop burst and the gap. Every phase lasts a
// whole number of NEC units of TICK_CYC clocks.
//
// Build option:
//   NEC_CARRIER_EN  undefined : ir_out is the envelope (1 = idle/space, 0 = mark).
//                   defined   : ir_out is the active-high LED drive. During marks it
//                               carries a CARRIER_DIV-cycle carrier that is high for
//                               the first CARRIER_DIV/3 cycles of each period.
//                               Otherwise it is 0.
//
// Ports:
//   sys_clk     in   system clock
//   sys_rst_n   in   asynchronous active-low reset
//   send_req    in   one-cycle pulse, start a data frame (wins over repeat_req)
//   repeat_req  in   one-cycle pulse, start a repeat code
//   addr, cmd   in   address / command bytes, captured when a request is accepted
//   busy        out  high from acceptance until the end of the gap
//   done        out  one-cycle pulse on the edge where busy falls
//   ir_out      out  envelope or LED drive (see build option)
module remote_send #(
    parameter int unsigned TICK_CYC    = 28125,
    parameter int unsigned GAP_TICKS   = 72,
    parameter int unsigned CARRIER_DIV = 1316
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       send_req,
    input  logic       repeat_req,
    input  logic [7:0] addr,
    input  logic [7:0] cmd,
    output logic       busy,
    output logic       done,
    output logic       ir_out
);

    localparam int unsigned PRESC_W   = $clog2(TICK_CYC);
    localparam int unsigned MAX_UNITS = (GAP_TICKS > 16) ? GAP_TICKS : 16;
    localparam int unsigned UNIT_W    = $clog2(MAX_UNITS + 1);

    typedef enum logic [2:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP_MARK,
        GAP
    } state_t;

    state_t              state, state_nxt;
    logic [PRESC_W-1:0]  presc;
    logic [UNIT_W-1:0]   units;
    logic [UNIT_W-1:0]   phase_len;
    logic [31:0]         shreg;
    logic [5:0]          bit_idx;
    logic                is_rep;
    logic                tick_end;
    logic                phase_end;
    logic                accept;
    logic                mark_nxt;
    logic                ir_q;

    always_comb begin
        phase_len = '0;
        case (state)
            LEAD_MARK:  phase_len = UNIT_W'(16);
            LEAD_SPACE: phase_len = is_rep ? UNIT_W'(4) : UNIT_W'(8);
            BIT_MARK:   phase_len = UNIT_W'(1);
            BIT_SPACE:  phase_len = shreg[0] ? UNIT_W'(3) : UNIT_W'(1);
            STOP_MARK:  phase_len = UNIT_W'(1);
            GAP:        phase_len = UNIT_W'(GAP_TICKS);
            default:    phase_len = '0;
        endcase

        tick_end  = (presc == PRESC_W'(TICK_CYC - 1));
        phase_end = (state != IDLE) && tick_end && (units == phase_len - 1'b1);
        accept    = (state == IDLE) && (send_req || repeat_req);

        state_nxt = state;
        case (state)
            IDLE:       if (accept)    state_nxt = LEAD_MARK;
            LEAD_MARK:  if (phase_end) state_nxt = LEAD_SPACE;
            LEAD_SPACE: if (phase_end) state_nxt = is_rep ? STOP_MARK : BIT_MARK;
            BIT_MARK:   if (phase_end) state_nxt = BIT_SPACE;
            BIT_SPACE:  if (phase_end) state_nxt = (bit_idx == 6'd31) ? STOP_MARK : BIT_MARK;
            STOP_MARK:  if (phase_end) state_nxt = GAP;
            GAP:        if (phase_end) state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase

        mark_nxt = (state_nxt == LEAD_MARK) || (state_nxt == BIT_MARK) ||
                   (state_nxt == STOP_MARK);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_nxt;
    end

    // busy decodes the state register directly, so it falls on the exit edge of GAP.
    // A request on that same edge is still refused.
    assign busy = (state != IDLE);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            presc   <= '0;
            units   <= '0;
            shreg   <= '0;
            bit_idx <= '0;
            is_rep  <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= (state == GAP) && phase_end;

            // Both counters restart at every phase boundary, so each phase is exactly
            // phase_len * TICK_CYC clocks long.
            if (state_nxt != state) begin
                presc <= '0;
                units <= '0;
            end else if (state != IDLE) begin
                if (tick_end) begin
                    presc <= '0;
                    units <= units + 1'b1;
                end else begin
                    presc <= presc + 1'b1;
                end
            end

            if (accept) begin
                shreg   <= {~cmd, cmd, ~addr, addr};
                is_rep  <= !send_req;
                bit_idx <= '0;
            end else if ((state == BIT_SPACE) && phase_end) begin
                shreg   <= shreg >> 1;
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

`ifdef NEC_CARRIER_EN
    localparam int unsigned CAR_W = $clog2(CARRIER_DIV);

    logic [CAR_W-1:0] car_cnt, car_nxt;

    // The carrier counter restarts on entry to each mark, so every burst begins with a
    // full high portion of the carrier.
    always_comb begin
        car_nxt = '0;
        if (mark_nxt && (state_nxt == state))
            car_nxt = (car_cnt == CAR_W'(CARRIER_DIV - 1)) ? '0 : car_cnt + 1'b1;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            car_cnt <= '0;
            ir_q    <= 1'b0;
        end else begin
            car_cnt <= car_nxt;
            ir_q    <= mark_nxt && (car_nxt < CAR_W'(CARRIER_DIV / 3));
        end
    end
`else
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) ir_q <= 1'b1;
        else            ir_q <= ~mark_nxt;
    end
`endif

    assign ir_out = ir_q;

endmodule
